// File: rtl/_seq_mul_pkg.sv
// Shared constants for the sequential multiplier: default operand width and FSM encoding.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// Contents:
//   BIT_WIDTH - default operand width
//   MUL_*     - 2-bit state encodings (IDLE, RUN, FIX, DONE)
package _seq_mul_pkg;

  localparam int BIT_WIDTH = 8;

  localparam logic [1:0] MUL_IDLE = 2'd0;
  localparam logic [1:0] MUL_RUN  = 2'd1;
  localparam logic [1:0] MUL_FIX  = 2'd2;
  localparam logic [1:0] MUL_DONE = 2'd3;

endpackage

// File: rtl/_dff_r.sv
// Plain W-bit register with asynchronous active-high clear.
// Latency: 1 cycle.
// Backpressure: none; the caller builds any enable as a D-side mux.
//
// Ports:
//   clk, rst - clock and asynchronous active-high reset (clears q to 0)
//   d        - next value
//   q        - registered value
module _dff_r #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule

// File: rtl/_seq_mul.sv
// Iterative shift-add multiplier, signed or unsigned, full 2n-bit product.
// Latency: n+1 cycles from accepted start to the done pulse; one product per n+2 cycles.
// Backpressure: start is taken only in IDLE or DONE; start while busy is dropped.
//
// Ports:
//   clk, rst   - clock and asynchronous active-high reset (abandons any operation)
//   start, sgn - request strobe; sgn=1 selects two's-complement operands
//   A, B       - multiplicand and multiplier, sampled with start
//   busy, done - busy in RUN/FIX; done is a one-cycle pulse in DONE
//   P_hi, P_lo - registered product, updated only in FIX
module _seq_mul
  import _seq_mul_pkg::*;
#(
  parameter int n = BIT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sgn,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] P_hi,
  output logic [n-1:0] P_lo
);

  localparam int CW = $clog2(n + 1);

  logic [1:0]     state;
  logic [CW-1:0]  cnt;
  logic [n-1:0]   mcand;
  logic [n-1:0]   mplier;
  logic [2*n-1:0] acc;
  logic           neg;

  logic [n-1:0]   a_mag;
  logic [n-1:0]   b_mag;
  logic           neg_in;
  logic [n:0]     sum;
  logic [2*n-1:0] acc_shift;
  logic [2*n-1:0] result;
  logic [2*n-1:0] prod_d;
  logic [2*n-1:0] prod_q;

  // Operate on magnitudes and restore the sign once at the end. Negating the
  // most-negative value wraps back to 2^(n-1), which is the correct unsigned
  // magnitude, so no extra bit is needed.
  always_comb begin
    a_mag  = (sgn && A[n-1]) ? (~A + 1'b1) : A;
    b_mag  = (sgn && B[n-1]) ? (~B + 1'b1) : B;
    neg_in = sgn & (A[n-1] ^ B[n-1]);
  end

  // n+1-bit add into the upper half; the carry lands in the accumulator MSB
  // as the pair shifts right.
  always_comb begin
    sum       = {1'b0, acc[2*n-1:n]} + (mplier[0] ? {1'b0, mcand} : '0);
    acc_shift = {sum, acc[n-1:1]};
    result    = neg ? (~acc + 1'b1) : acc;
    prod_d    = (state == MUL_FIX) ? result : prod_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= MUL_IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      neg    <= 1'b0;
    end else begin
      case (state)
        MUL_IDLE, MUL_DONE: begin
          if (start) begin
            neg    <= neg_in;
            mcand  <= a_mag;
            mplier <= b_mag;
            acc    <= '0;
            cnt    <= CW'(n);
            state  <= MUL_RUN;
          end else begin
            state  <= MUL_IDLE;
          end
        end
        MUL_RUN: begin
          acc    <= acc_shift;
          mplier <= mplier >> 1;
          cnt    <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= MUL_FIX;
        end
        MUL_FIX: state <= MUL_DONE;
        default: state <= MUL_IDLE;
      endcase
    end
  end

  // Output product register: only the FIX cycle loads a new value, so the
  // previous product stays visible through IDLE and the next RUN.
  _dff_r #(.W(2*n)) u_prod (
    .clk (clk),
    .rst (rst),
    .d   (prod_d),
    .q   (prod_q)
  );

  assign P_hi = prod_q[2*n-1:n];
  assign P_lo = prod_q[n-1:0];
  assign busy = (state == MUL_RUN) || (state == MUL_FIX);
  assign done = (state == MUL_DONE);

endmodule
